out_port_uart_tx: RTL and testbench

OUT_PORT_UART_TX -- requirements
Module: out_port_uart_tx

---
 rtl/out_port_uart_tx_pkg.sv | 6 +
 rtl/out_port_uart_tx_if.sv | 9 +
 rtl/out_port_uart_tx_byte_fifo.sv | 39 +++
 rtl/out_port_uart_tx.sv | 88 ++++++++
 tb/tb_out_port_uart_tx.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/out_port_uart_tx_pkg.sv
// out_port_uart_tx_pkg: transmit FSM encodings and UART framing constants
package out_port_uart_tx_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
   localparam int DATA_BITS = 8;
   localparam int FRAME_BITS = 10;
endpackage

// File: rtl/out_port_uart_tx_if.sv
// out_port_uart_tx_if: cpu output port in, serial line and status out
interface out_port_uart_tx_if;
   logic [7:0] cpu_out;
   logic tx;
   logic busy;
   logic overflow;
   modport master(output cpu_out, input tx, busy, overflow);
   modport slave(input cpu_out, output tx, busy, overflow);
endinterface

// File: rtl/out_port_uart_tx_byte_fifo.sv
// byte_fifo: small power-of-two FIFO with fall-through read data
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] rd, wr;
   logic [AW:0] cnt;
   logic wr_en, rd_en;
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign dout = mem[rd];
   assign empty = cnt == '0;
   assign full = cnt == (AW+1)'(DEPTH);
   // storage array, written without reset
   always_ff @(posedge clk)
      if (wr_en) mem[wr] <= din;
   // pointers and occupancy; a push and pop together leave the count unchanged
   always_ff @(posedge clk)
      if (rst) begin
         rd <= '0;
         wr <= '0;
         cnt <= '0;
      end else begin
         if (wr_en) wr <= wr + 1'b1;
         if (rd_en) rd <= rd + 1'b1;
         cnt <= cnt + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
      end
endmodule

// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx: sends each changed cpu_out byte as an 8N1 UART frame
module out_port_uart_tx
   import out_port_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH = 4
) (
   input logic clk,
   input logic rst,
   out_port_uart_tx_if.slave p
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = $clog2(DATA_BITS);
   tx_state_t state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [IW-1:0] idx, idx_d;
   logic [7:0] sh, sh_d, last, dout;
   logic tx_q, tx_d, ovf, pop, push, chg, empty, full, done;
   assign chg = p.cpu_out != last;
   assign push = chg && (!full || pop);
   assign done = cnt == CW'(CLKS_PER_BIT - 1);
   assign p.tx = tx_q;
   assign p.busy = state != IDLE || !empty;
   assign p.overflow = ovf;
   byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(push), .din(p.cpu_out),
      .pop(pop), .dout(dout), .empty(empty), .full(full)
   );
   // change detector: track last sampled value, flag bytes lost to a full FIFO
   always_ff @(posedge clk)
      if (rst) begin
         last <= '0;
         ovf <= 1'b0;
      end else begin
         last <= p.cpu_out;
         ovf <= ovf | (chg & full & !pop);
      end
   // transmit state register; tx follows the current state one cycle later
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         sh <= '0;
         tx_q <= 1'b1;
      end else begin
         state <= state_d;
         cnt <= cnt_d;
         idx <= idx_d;
         sh <= sh_d;
         tx_q <= tx_d;
      end
   // next-state, bit timing and line level for the current state
   always_comb begin
      state_d = state;
      cnt_d = cnt;
      idx_d = idx;
      sh_d = sh;
      pop = 1'b0;
      tx_d = 1'b1;
      case (state)
         IDLE:
            if (!empty) begin
               pop = 1'b1;
               sh_d = dout;
               cnt_d = '0;
               state_d = START;
            end
         START: begin
            tx_d = 1'b0;
            cnt_d = done ? '0 : cnt + 1'b1;
            idx_d = done ? '0 : idx;
            state_d = done ? DATA : START;
         end
         DATA: begin
            tx_d = sh[0];
            cnt_d = done ? '0 : cnt + 1'b1;
            sh_d = done ? sh >> 1 : sh;
            idx_d = (done && idx != IW'(DATA_BITS - 1)) ? idx + 1'b1 : idx;
            state_d = (done && idx == IW'(DATA_BITS - 1)) ? STOP : DATA;
         end
         default: begin
            cnt_d = done ? '0 : cnt + 1'b1;
            state_d = done ? IDLE : STOP;
         end
      endcase
   end
endmodule

// File: tb/tb_out_port_uart_tx.sv
// tb_out_port_uart_tx: directed checks of framing, latency, queueing, overflow and reset
module tb_out_port_uart_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   int e, c, g;
   logic [7:0] b;
   logic [9:0] line;
   logic [3:0] s;
   out_port_uart_tx_if bus();
   out_port_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .p(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic rx_frame(output logic [7:0] v, output int gap);
      logic [7:0] r;
      r = '0;
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (bus.tx !== 1'b0 && gap < 200);
      if (bus.tx !== 1'b0) begin
         chk("rx_timeout", 1, 0);
         v = 8'hxx;
         return;
      end
      repeat (2) @(negedge clk);
      chk("start_bit", bus.tx, 0);
      for (int i = 0; i < 8; i++) begin
         repeat (4) @(negedge clk);
         r[i] = bus.tx;
      end
      repeat (4) @(negedge clk);
      chk("stop_bit", bus.tx, 1);
      v = r;
   endtask

   task automatic lows(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(negedge clk);
         if (bus.tx !== 1'b1) cnt++;
      end
   endtask

   initial begin
      bus.cpu_out = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_tx", bus.tx, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ovf", bus.overflow, 0);
      rst = 1'b0;
      e = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) e++;
      end
      chk("hold00", e, 0);
      bus.cpu_out = 8'h01;
      @(negedge clk);
      chk("lat_e0_tx", bus.tx, 1);
      chk("lat_e0_busy", bus.busy, 1);
      @(negedge clk);
      chk("lat_e1_tx", bus.tx, 1);
      @(negedge clk);
      chk("lat_e2_tx", bus.tx, 0);
      line = {1'b1, 8'h01, 1'b0};
      for (int k = 0; k < 10; k++) begin
         s = '0;
         for (int j = 0; j < 4; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            s[j] = bus.tx;
         end
         chk($sformatf("f01_bit%0d", k), s, {4{line[k]}});
      end
      lows(38, c);
      chk("f01_idle", c, 0);
      chk("f01_busy", bus.busy, 0);
      chk("f01_ovf", bus.overflow, 0);
      bus.cpu_out = 8'h02;
      @(negedge clk);
      bus.cpu_out = 8'h03;
      rx_frame(b, g);
      chk("f02", b, 8'h02);
      rx_frame(b, g);
      chk("f03", b, 8'h03);
      chk("gap_b2b", g, 3);
      lows(20, c);
      chk("f03_idle", c, 0);
      chk("f03_busy", bus.busy, 0);
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               bus.cpu_out = 8'h11 + 8'(i);
               @(negedge clk);
            end
         end
         begin
            logic [7:0] rb;
            int rg;
            for (int i = 0; i < 5; i++) begin
               rx_frame(rb, rg);
               chk($sformatf("burst%0d", i), rb, 8'h11 + i);
            end
         end
      join
      chk("burst_ovf", bus.overflow, 1);
      lows(60, c);
      chk("burst_no6th", c, 0);
      chk("burst_busy", bus.busy, 0);
      chk("ovf_sticky", bus.overflow, 1);
      bus.cpu_out = 8'h5A;
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (bus.tx !== 1'b0 && g < 200);
      chk("rst_frame_seen", bus.tx, 0);
      repeat (17) @(negedge clk);
      chk("rst_pre_d3", bus.tx, 1);
      chk("rst_pre_busy", bus.busy, 1);
      rst = 1'b1;
      bus.cpu_out = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_tx", bus.tx, 1);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_ovf", bus.overflow, 0);
      lows(60, c);
      chk("midrst_quiet", c, 0);
      chk("midrst_busy2", bus.busy, 0);
      bus.cpu_out = 8'h05;
      rx_frame(b, g);
      chk("f05", b, 8'h05);
      chk("f05_lat", g, 3);
      lows(50, c);
      chk("f05_once", c, 0);
      bus.cpu_out = 8'h00;
      rx_frame(b, g);
      chk("f00", b, 8'h00);
      lows(30, c);
      chk("f00_idle", c, 0);
      chk("f00_busy", bus.busy, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
